// File: rtl/lcd_pkg.sv
// Shared constants, state type and character helper
// for the LCD frame buffer.
package lcd_pkg;

  localparam int LCD_CHARS = 32;
  localparam int LCD_COLS  = 16;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MAX   = 8'h7E;

  typedef enum logic {
    IDLE,
    CLEAR
  } lcd_state_e;

  // Non-printable codes would garble the panel, so show a blank instead
  function automatic logic [7:0] lcd_sanitize(
    input logic [7:0] c
  );
    if (c < ASCII_SPACE || c > ASCII_MAX)
      return ASCII_SPACE;
    return c;
  endfunction

endpackage

// File: rtl/lcd_scroll_tick.sv
// Marquee timebase: divides clk down to scroll steps
// and keeps the line-0 rotation offset.
module lcd_scroll_tick #(
  parameter int SCROLL_DIV = 12_500_000,
  parameter int CNT_W      = $clog2(SCROLL_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scroll_en,
  output logic [3:0] scroll_pos
);

  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_pos;
  logic             w_tc;

  assign w_tc       = (r_cnt == CNT_W'(SCROLL_DIV - 1));
  assign scroll_pos = r_pos;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_pos <= '0;
    end else if (!scroll_en) begin
      r_cnt <= '0;
      r_pos <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_pos <= r_pos + 4'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lcd_frame_buf.sv
// Double-buffered 32-char frame store with clear,
// deferred commit and line-0 marquee.
module lcd_frame_buf
  import lcd_pkg::*;
#(
  parameter int SCROLL_DIV = 12_500_000,
  parameter int CNT_W      = $clog2(SCROLL_DIV)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [4:0]   wr_addr,
  input  logic [7:0]   wr_data,
  input  logic         clr_req,
  input  logic         commit,
  input  logic         scroll_en,
  output logic         busy,
  output logic [3:0]   scroll_pos,
  output logic [255:0] frame_chars
);

  lcd_state_e r_state;
  lcd_state_e w_state_nx;
  logic [4:0] r_clr_idx;
  logic [4:0] w_clr_idx_nx;
  logic       r_pend;
  logic       w_pend_nx;
  logic       w_ready;
  logic       w_copy;
  logic       w_clr_we;
  logic       w_wr_fire;

  logic [7:0] r_back  [LCD_CHARS];
  logic [7:0] r_front [LCD_CHARS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_clr_idx <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_clr_idx <= w_clr_idx_nx;
      r_pend    <= w_pend_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_clr_idx_nx = r_clr_idx;
    w_pend_nx    = r_pend;
    w_ready      = 1'b0;
    w_copy       = 1'b0;
    w_clr_we     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready   = !clr_req;
        w_copy    = commit | r_pend;
        w_pend_nx = 1'b0;
        if (clr_req) begin
          w_state_nx   = CLEAR;
          w_clr_idx_nx = '0;
        end
      end
      CLEAR: begin
        w_clr_we     = 1'b1;
        w_clr_idx_nx = r_clr_idx + 5'd1;
        if (commit)
          w_pend_nx = 1'b1;
        if (r_clr_idx == 5'(LCD_CHARS - 1))
          w_state_nx = IDLE;
      end
      default: ;
    endcase
  end

  assign wr_ready  = w_ready & reset;
  assign w_wr_fire = wr_valid & wr_ready;
  assign busy      = (r_state == CLEAR) | r_pend;

  // Copy reads r_back before this edge's write lands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LCD_CHARS; i++) begin
        r_back[i]  <= ASCII_SPACE;
        r_front[i] <= ASCII_SPACE;
      end
    end else begin
      if (w_wr_fire)
        r_back[wr_addr] <= lcd_sanitize(wr_data);
      if (w_clr_we)
        r_back[r_clr_idx] <= ASCII_SPACE;
      if (w_copy)
        for (int i = 0; i < LCD_CHARS; i++)
          r_front[i] <= r_back[i];
    end
  end

  lcd_scroll_tick #(
    .SCROLL_DIV (SCROLL_DIV),
    .CNT_W      (CNT_W)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .scroll_en  (scroll_en),
    .scroll_pos (scroll_pos)
  );

  always_comb begin
    frame_chars = '0;
    for (int j = 0; j < LCD_COLS; j++)
      frame_chars[8*j +: 8] =
        r_front[5'((j + int'(scroll_pos)) % LCD_COLS)];
    for (int j = LCD_COLS; j < LCD_CHARS; j++)
      frame_chars[8*j +: 8] = r_front[5'(j)];
  end

endmodule

// File: tb/tb_lcd_frame_buf.sv
// Scoreboard bench for lcd_frame_buf: per-cycle expected
// outputs from a behavioural model, checked by a monitor.
module tb_lcd_frame_buf;

  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_valid;
  logic         wr_ready;
  logic [4:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         clr_req;
  logic         commit;
  logic         scroll_en;
  logic         busy;
  logic [3:0]   scroll_pos;
  logic [255:0] frame_chars;

  always #5 clk = ~clk;

  lcd_frame_buf #(.SCROLL_DIV(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .clr_req     (clr_req),
    .commit      (commit),
    .scroll_en   (scroll_en),
    .busy        (busy),
    .scroll_pos  (scroll_pos),
    .frame_chars (frame_chars)
  );

  typedef struct {
    int           cyc;
    logic [255:0] fr;
    logic         rdy;
    logic         bsy;
    logic [3:0]   pos;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic [7:0] mb[32];
  logic [7:0] mf[32];
  int         clr_left;
  int         en_cnt;
  bit         pend;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ref_san(logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) return c;
    return 8'h20;
  endfunction

  function automatic int ref_pos();
    return (en_cnt / DIV) % 16;
  endfunction

  function automatic logic [255:0] ref_frame();
    logic [255:0] r;
    int p;
    p = ref_pos();
    r = '0;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = mf[(j + p) % 16];
    for (int j = 16; j < 32; j++) r[8*j +: 8] = mf[j];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mb[i] = 8'h20;
      mf[i] = 8'h20;
    end
    clr_left = 0;
    pend     = 1'b0;
    en_cnt   = 0;
  endtask

  task automatic model_edge();
    if (clr_left > 0) begin
      mb[32 - clr_left] = 8'h20;
      clr_left--;
      if (commit) pend = 1'b1;
    end else begin
      if (commit || pend) begin
        mf   = mb;
        pend = 1'b0;
      end
      if (clr_req) clr_left = 32;
      else if (wr_valid) mb[wr_addr] = ref_san(wr_data);
    end
    en_cnt = scroll_en ? en_cnt + 1 : 0;
  endtask

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("frame", frame_chars, e.fr);
      chk("wr_ready", 256'(wr_ready), 256'(e.rdy));
      chk("busy", 256'(busy), 256'(e.bsy));
      chk("scroll_pos", 256'(scroll_pos), 256'(e.pos));
    end
  end

  task automatic step();
    exp_t e;
    e.cyc = cyc;
    e.fr  = ref_frame();
    e.rdy = reset && clr_left == 0 && !clr_req;
    e.bsy = (clr_left > 0) || pend;
    e.pos = 4'(ref_pos());
    q.push_back(e);
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic drv(logic v, logic [4:0] a, logic [7:0] d,
                     logic c, logic m);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    clr_req  = c;
    commit   = m;
    step();
  endtask

  task automatic idle(int n);
    repeat (n) drv(1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    string s;
    s = "0123456789ABCDEF";
    reset = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clr_req = 1'b0; commit = 1'b0; scroll_en = 1'b0;
    model_reset();
    @(posedge clk); #1;
    idle(2);
    reset = 1'b1;
    idle(1);
    // 'H' to line 1 col 0
    drv(1'b1, 5'd16, 8'h48, 1'b0, 1'b0);
    drv(1'b0, 5'd0, 8'h00, 1'b0, 1'b1);
    idle(1);
    // sanitisation boundaries
    drv(1'b1, 5'd3, 8'h0A, 1'b0, 1'b0);
    drv(1'b0, 5'd0, 8'h00, 1'b0, 1'b1);
    drv(1'b1, 5'd4, 8'h7F, 1'b0, 1'b0);
    drv(1'b1, 5'd5, 8'h7E, 1'b0, 1'b0);
    drv(1'b1, 5'd6, 8'h1F, 1'b0, 1'b0);
    drv(1'b1, 5'd7, 8'h20, 1'b0, 1'b0);
    drv(1'b0, 5'd0, 8'h00, 1'b0, 1'b1);
    idle(1);
    // marquee over a full wrap
    for (int i = 0; i < 16; i++)
      drv(1'b1, 5'(i), s[i], 1'b0, 1'b0);
    drv(1'b0, 5'd0, 8'h00, 1'b0, 1'b1);
    scroll_en = 1'b1;
    idle(70);
    scroll_en = 1'b0;
    idle(3);
    // clear beats write, commit deferred during clear
    for (int i = 0; i < 32; i++)
      drv(1'b1, 5'(i), 8'h41, 1'b0, 1'b0);
    drv(1'b0, 5'd0, 8'h00, 1'b0, 1'b1);
    drv(1'b1, 5'd0, 8'h42, 1'b1, 1'b0);
    idle(9);
    drv(1'b0, 5'd0, 8'h00, 1'b0, 1'b1);
    idle(26);
    // commit same cycle as write
    drv(1'b1, 5'd5, 8'h5A, 1'b0, 1'b1);
    idle(1);
    drv(1'b0, 5'd0, 8'h00, 1'b0, 1'b1);
    idle(1);
    // reset mid-clear with commit pending and scroll running
    scroll_en = 1'b1;
    drv(1'b1, 5'd9, 8'h51, 1'b0, 1'b1);
    drv(1'b0, 5'd0, 8'h00, 1'b1, 1'b0);
    idle(5);
    drv(1'b0, 5'd0, 8'h00, 1'b0, 1'b1);
    idle(9);
    reset = 1'b0;
    model_reset();
    idle(2);
    reset = 1'b1;
    idle(2);
    scroll_en = 1'b0;
    idle(1);
    // randomized traffic
    repeat (2500) begin
      if ($urandom_range(0, 199) == 0) scroll_en = ~scroll_en;
      drv(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          8'($urandom_range(0, 255)),
          $urandom_range(0, 59) == 0,
          $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp += q.size();
      n_bad += q.size();
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
